// File: rtl/imem_boot_loader.sv
// Purpose: fills instruction memory from a framed byte stream (sync, 16-bit length, words, checksum) and releases the core from reset.
// Latency: all outputs registered; a state change or word write is visible the cycle after the edge that accepts the causing byte.
// Backpressure: accepts one byte per cycle in every state except RUN, where in_ready is held low.
module imem_boot_loader #(
    parameter int         MEM_DEPTH = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CW        = $clog2(MEM_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          reboot,
    output logic          imem_we,
    output logic [31:0]   imem_wd,
    output logic          core_rstn,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MEM_DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   word_q, word_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] words_q, words_d;
    logic [31:0]   wd_q, wd_d;
    logic          we_q, we_d;
    logic          in_ready_q, core_rstn_q, busy_q, done_q, error_q;

    logic          xfer;
    logic          start_img;
    logic [15:0]   n16;

    assign xfer = in_valid && in_ready_q;
    assign n16  = {in_data, len_lo_q};

    // Next-state, datapath and word-write decisions for the loader FSM.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        words_d    = words_q;
        wd_d       = wd_q;
        we_d       = 1'b0;
        start_img  = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: begin
                // Only a sync byte starts an image; anything else is dropped.
                if (xfer && in_data == SYNC_BYTE) begin
                    start_img = 1'b1;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd0) begin
                        len_lo_d   = in_data;
                        byte_idx_d = 2'd1;
                    end else begin
                        byte_idx_d = 2'd0;
                        if (n16 == 16'd0 || n16 > MAX_N) begin
                            state_d = S_ERR;
                        end else begin
                            len_d   = n16[CW-1:0];
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q + in_data;
                    if (byte_idx_q == 2'd3) begin
                        wd_d       = {in_data, word_q};
                        we_d       = 1'b1;
                        words_d    = words_q + CW'(1);
                        byte_idx_d = 2'd0;
                        if (words_d == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = in_data;
                            2'd1:    word_d[15:8]  = in_data;
                            default: word_d[23:16] = in_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                if (reboot) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh image restarts all per-image bookkeeping.
        if (start_img) begin
            byte_idx_d = 2'd0;
            word_d     = 24'd0;
            csum_d     = 8'd0;
            len_lo_d   = 8'd0;
            len_d      = '0;
            words_d    = '0;
        end
    end

    // State, datapath and registered status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= 2'd0;
            word_q      <= 24'd0;
            csum_q      <= 8'd0;
            len_lo_q    <= 8'd0;
            len_q       <= '0;
            words_q     <= '0;
            wd_q        <= 32'd0;
            we_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            words_q     <= words_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            in_ready_q  <= (state_d != S_RUN);
            core_rstn_q <= (state_d == S_RUN);
            busy_q      <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
            done_q      <= (state_d == S_RUN);
            error_q     <= (state_d == S_ERR);
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_wd      = wd_q;
    assign core_rstn    = core_rstn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Purpose: directed checks of the boot loader: framing, length bounds, checksum, stalls, reset and reboot.
// Latency: outputs sampled one time unit after the falling edge, i.e. the cycle after the causing edge.
// Backpressure: byte sender waits (bounded) for in_ready before presenting each byte.
module tb_imem_boot_loader;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst, in_valid, reboot;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, core_rstn, busy, done, error;
    logic [31:0]   imem_wd;
    logic [CW-1:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] wr_q[$];
    int          wr_cyc[$];
    logic [31:0] img[$];

    imem_boot_loader #(.MEM_DEPTH(256), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reboot(reboot), .imem_we(imem_we),
        .imem_wd(imem_wd), .core_rstn(core_rstn), .busy(busy),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every instruction-memory write and the cycle it appeared in.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_q.push_back(imem_wd);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        reboot   = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_core_rstn"}, core_rstn, 0);
        chk({p, "_imem_we"}, imem_we, 0);
        chk({p, "_imem_wd"}, imem_wd, 0);
        chk({p, "_words"}, words_loaded, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_error"}, error, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_in_ready"}, in_ready, 1);
    endtask

    // Present one byte after an optional stall; it is accepted on the next edge with in_ready high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int gapmax);
        return (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    endfunction

    // Sync, little-endian length and little-endian words from img; checksum is sent by the caller.
    task automatic send_image(input int gapmax);
        int n;
        n = img.size();
        send_byte(8'hA5, pick_gap(gapmax));
        send_byte(n[7:0], pick_gap(gapmax));
        send_byte(n[15:8], pick_gap(gapmax));
        foreach (img[i]) begin
            send_byte(img[i][7:0],   pick_gap(gapmax));
            send_byte(img[i][15:8],  pick_gap(gapmax));
            send_byte(img[i][23:16], pick_gap(gapmax));
            send_byte(img[i][31:24], pick_gap(gapmax));
        end
    endtask

    function automatic logic [7:0] csum_of();
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) s = s + img[i][7:0] + img[i][15:8] + img[i][23:16] + img[i][31:24];
        return s;
    endfunction

    task automatic check_nominal_writes(input string p);
        chk({p, "_nwr"}, wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk({p, "_wd0"}, wr_q[0], 32'h12345678);
            chk({p, "_wd1"}, wr_q[1], 32'hDEADBEEF);
        end
    endtask

    initial begin
        int bad;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; reboot = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_reset_vals("rst");
        clear_log();

        // Nominal image, back-to-back bytes; data-byte sum 0x4C
        img = '{32'h12345678, 32'hDEADBEEF};
        send_image(0);
        tick();
        chk("nom_pre_rstn", core_rstn, 0);
        chk("nom_pre_busy", busy, 1);
        check_nominal_writes("nom");
        if (wr_cyc.size() == 2) chk("nom_wr_spacing", wr_cyc[1] - wr_cyc[0], 4);
        send_byte(8'h4C, 0);
        tick();
        chk("nom_rstn", core_rstn, 1);
        chk("nom_done", done, 1);
        chk("nom_words", words_loaded, 2);
        chk("nom_in_ready", in_ready, 0);
        chk("nom_busy", busy, 0);

        // Bytes during RUN are ignored, then reboot
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) tick();
        chk("run_words_hold", words_loaded, 2);
        chk("run_done_hold", done, 1);
        chk("run_busy", busy, 0);
        in_valid = 1'b0;
        reboot   = 1'b1;
        @(posedge clk);
        #1;
        reboot = 1'b0;
        tick();
        chk("rbt_rstn", core_rstn, 0);
        chk("rbt_in_ready", in_ready, 1);
        chk("rbt_done", done, 0);
        clear_log();
        img = '{32'h11223344, 32'hCAFEF00D, 32'h00000000};
        send_image(0);
        send_byte(csum_of(), 0);
        tick();
        chk("rbt2_nwr", wr_q.size(), 3);
        if (wr_q.size() == 3) chk("rbt2_wd1", wr_q[1], 32'hCAFEF00D);
        chk("rbt2_rstn", core_rstn, 1);
        chk("rbt2_words", words_loaded, 3);

        // Bad checksum, then recovery by resending
        do_reset();
        img = '{32'h12345678, 32'hDEADBEEF};
        send_image(0);
        send_byte(8'h00, 0);
        tick();
        check_nominal_writes("bad");
        chk("bad_error", error, 1);
        chk("bad_rstn", core_rstn, 0);
        repeat (3) tick();
        chk("bad_rstn_hold", core_rstn, 0);
        clear_log();
        send_image(0);
        send_byte(8'h4C, 0);
        tick();
        check_nominal_writes("rec");
        chk("rec_done", done, 1);
        chk("rec_error", error, 0);
        chk("rec_rstn", core_rstn, 1);

        // Length bounds: N=0 and N=257 are rejected
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick();
        chk("n0_error", error, 1);
        chk("n0_nwr", wr_q.size(), 0);
        send_byte(8'hA5, 0);
        tick();
        chk("err_resync_busy", busy, 1);
        chk("err_resync_error", error, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        tick();
        chk("n257_error", error, 1);
        chk("n257_busy", busy, 0);

        // N=256, full memory
        do_reset();
        img.delete();
        for (int k = 0; k < 256; k++) img.push_back((32'(k) * 32'h00010003) ^ 32'h5AC30F96);
        send_image(0);
        send_byte(csum_of(), 0);
        tick();
        chk("n256_done", done, 1);
        chk("n256_words", words_loaded, 256);
        chk("n256_nwr", wr_q.size(), 256);
        bad = 0;
        if (wr_q.size() == 256) foreach (img[i]) if (wr_q[i] !== img[i]) bad++;
        chk("n256_data", bad, 0);

        // Junk before sync, random stalls throughout
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'hFF, 2);
        send_byte(8'h13, 0);
        tick();
        chk("junk_busy", busy, 0);
        chk("junk_error", error, 0);
        img = '{32'h12345678, 32'hDEADBEEF};
        send_image(3);
        tick();
        chk("stall_pre_rstn", core_rstn, 0);
        send_byte(8'h4C, 2);
        tick();
        check_nominal_writes("stall");
        chk("stall_rstn", core_rstn, 1);
        chk("stall_words", words_loaded, 2);

        // Reset mid-load after the 6th data byte
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_reset_vals("mid");
        repeat (6) tick();
        chk("mid_nwr", wr_q.size(), 1);
        clear_log();
        send_image(0);
        send_byte(8'h4C, 0);
        tick();
        check_nominal_writes("mid2");
        chk("mid2_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
